// File: rtl/road_scroll_if.sv
// road_scroll_if: renderer/button side signals of the road scroll controller
interface road_scroll_if;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        button_c;
  logic        button_u;
  logic        button_d;
  logic        collision;
  logic        scroll_step;
  logic        seg_reload;
  logic [1:0]  speed;
  logic [1:0]  regime_status;
  logic [15:0] score;
  modport master (
    output h_coord, v_coord, button_c, button_u, button_d, collision,
    input  scroll_step, seg_reload, speed, regime_status, score
  );
  modport slave (
    input  h_coord, v_coord, button_c, button_u, button_d, collision,
    output scroll_step, seg_reload, speed, regime_status, score
  );
endinterface

// File: rtl/road_scroll_ctrl.sv
// road_scroll_ctrl: IDLE/RUN/PAUSE/CRASH regime FSM, frame-divided scroll pulses, segment reloads and score; define SCROLL_DEBOUNCE_EN to debounce the buttons
module road_scroll_ctrl #(
  parameter int H_PIXELS     = 800,
  parameter int V_PIXELS     = 600,
  parameter int SEG_LEN      = 200,
  parameter int CRASH_FRAMES = 120,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic pixel_clk,
  input  logic rst_n,
  road_scroll_if.slave bus
);
  localparam int SW = $clog2(SEG_LEN + 1);
  localparam int CW = $clog2(CRASH_FRAMES + 1);
  localparam logic [SW-1:0] SEG_MAX = SW'(SEG_LEN - 1);
  localparam logic [CW-1:0] CRASH_MAX = CW'(CRASH_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, CRASH} state_t;
  state_t state;
  logic [2:0] s0, s1, lvl, prev, press;
  logic [1:0] div_cnt, speed;
  logic [SW-1:0] seg_cnt;
  logic [CW-1:0] crash_cnt;
  logic [15:0] score;
  logic scroll_step, seg_reload, eof;
  assign eof = (bus.h_coord == 11'(H_PIXELS - 1)) && (bus.v_coord == 10'(V_PIXELS - 1));
  assign press = lvl & ~prev;
  // two-stage synchroniser for the c/u/d pins plus the edge-detect history
  always_ff @(posedge pixel_clk)
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
      prev <= '0;
    end else begin
      s0 <= {bus.button_c, bus.button_u, bus.button_d};
      s1 <= s0;
      prev <= lvl;
    end
`ifdef SCROLL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DW-1:0] cnt;
    // accept a new level only after it has persisted for DEBOUNCE_CYC cycles
    always_ff @(posedge pixel_clk)
      if (!rst_n) begin
        cnt <= '0;
        lvl[i] <= 1'b0;
      end else if (s1[i] == lvl[i]) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
        cnt <= '0;
        lvl[i] <= s1[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
  end
`else
  assign lvl = s1;
`endif
  // regime FSM with the frame divider, segment counter and score
  always_ff @(posedge pixel_clk)
    if (!rst_n) begin
      state <= IDLE;
      scroll_step <= 1'b0;
      seg_reload <= 1'b0;
      speed <= '0;
      score <= '0;
      div_cnt <= '0;
      seg_cnt <= SEG_MAX;
      crash_cnt <= '0;
    end else begin
      scroll_step <= 1'b0;
      seg_reload <= 1'b0;
      case (state)
        IDLE: if (press[2]) begin
          state <= RUN;
          score <= '0;
          speed <= '0;
          div_cnt <= '0;
          seg_cnt <= SEG_MAX;
        end
        RUN: if (bus.collision) state <= CRASH;
          else if (press[2]) state <= PAUSE;
          else begin
            if (press[1] && !press[0] && speed != 2'd3) speed <= speed + 2'd1;
            else if (press[0] && !press[1] && speed != 2'd0) speed <= speed - 2'd1;
            if (eof && div_cnt >= 2'd3 - speed) begin
              scroll_step <= 1'b1;
              div_cnt <= '0;
              score <= (score == 16'hFFFF) ? score : score + 16'd1;
              seg_reload <= seg_cnt == '0;
              seg_cnt <= (seg_cnt == '0) ? SEG_MAX : seg_cnt - 1'b1;
            end else if (eof) div_cnt <= div_cnt + 2'd1;
          end
        PAUSE: if (press[2]) state <= RUN;
        CRASH: if (eof) begin
          state <= (crash_cnt == CRASH_MAX) ? IDLE : CRASH;
          crash_cnt <= (crash_cnt == CRASH_MAX) ? '0 : crash_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.scroll_step = scroll_step;
  assign bus.seg_reload = seg_reload;
  assign bus.speed = speed;
  assign bus.regime_status = state;
  assign bus.score = score;
endmodule

// File: tb/tb_road_scroll_ctrl.sv
// tb_road_scroll_ctrl: directed plus random regime/speed/frame stimulus against a frame-level reference model
module tb_road_scroll_ctrl;
  localparam int SEG = 4;
  localparam int CRF = 6;
`ifdef SCROLL_DEBOUNCE_EN
  localparam int HOLD = 20;
  localparam int SETTLE = 24;
  localparam int PRESS_EDGE = 19;
`else
  localparam int HOLD = 1;
  localparam int SETTLE = 3;
  localparam int PRESS_EDGE = 3;
`endif
  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nfail = 0;
  int m_st, m_spd, m_w, m_steps, m_cf;
  road_scroll_if bus();
  road_scroll_ctrl #(.SEG_LEN(SEG), .CRASH_FRAMES(CRF)) dut (.pixel_clk(pixel_clk), .rst_n(rst_n), .bus(bus));
  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_score();
    return m_steps > 65535 ? 65535 : m_steps;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".regime"}, 32'(bus.regime_status), 32'(m_st));
    chk({tag, ".speed"}, 32'(bus.speed), 32'(m_spd));
    chk({tag, ".score"}, 32'(bus.score), 32'(exp_score()));
  endtask

  task automatic cyc();
    bus.h_coord = 11'($urandom_range(0, 798));
    bus.v_coord = 10'($urandom_range(0, 599));
    @(posedge pixel_clk);
    #1;
    chk("no_step", 32'(bus.scroll_step), 32'd0);
  endtask

  task automatic frame();
    bit step, rel;
    repeat ($urandom_range(1, 4)) cyc();
    bus.h_coord = 11'd799;
    bus.v_coord = 10'd599;
    @(posedge pixel_clk);
    #1;
    step = 0;
    rel = 0;
    if (m_st == 1) begin
      m_w++;
      if (m_w >= 4 - m_spd) begin
        step = 1;
        m_w = 0;
        m_steps++;
        rel = (m_steps % SEG) == 0;
      end
    end else if (m_st == 3) begin
      m_cf++;
      if (m_cf == CRF) begin
        m_st = 0;
        m_cf = 0;
      end
    end
    chk("eof.step", 32'(bus.scroll_step), 32'(step));
    chk("eof.reload", 32'(bus.seg_reload), 32'(rel));
    check_all("eof");
  endtask

  task automatic btn(input bit c, input bit u, input bit d);
    bus.button_c = c;
    bus.button_u = u;
    bus.button_d = d;
    repeat (HOLD) cyc();
    bus.button_c = 0;
    bus.button_u = 0;
    bus.button_d = 0;
    repeat (SETTLE) cyc();
    if (m_st == 0 && c) begin
      m_st = 1;
      m_spd = 0;
      m_w = 0;
      m_steps = 0;
    end else if (m_st == 1) begin
      if (c) m_st = 2;
      else if (u && !d) m_spd = m_spd == 3 ? 3 : m_spd + 1;
      else if (d && !u) m_spd = m_spd == 0 ? 0 : m_spd - 1;
    end else if (m_st == 2 && c) m_st = 1;
    check_all("btn");
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (4) cyc();
    m_st = 0;
    m_spd = 0;
    m_w = 0;
    m_steps = 0;
    m_cf = 0;
    check_all("reset");
    chk("reset.reload", 32'(bus.seg_reload), 32'd0);
    rst_n = 1;
  endtask

  initial begin
    bus.button_c = 0;
    bus.button_u = 0;
    bus.button_d = 0;
    bus.collision = 0;
    do_reset();
    btn(0, 1, 0);
`ifdef SCROLL_DEBOUNCE_EN
    btn(1, 0, 0);
`else
    bus.button_c = 1;
    cyc();
    bus.button_c = 0;
    cyc();
    chk("latency.edge2", 32'(bus.regime_status), 32'd0);
    cyc();
    chk("latency.edge3", 32'(bus.regime_status), 32'd1);
    cyc();
    m_st = 1;
    m_spd = 0;
    m_w = 0;
    m_steps = 0;
    check_all("start");
`endif
    repeat (12) frame();
    repeat (40) begin
      case ($urandom_range(0, 9))
        0: btn(0, 1, 0);
        1: btn(0, 0, 1);
        2: btn(0, 1, 1);
        default: frame();
      endcase
    end
    repeat (3) btn(0, 1, 0);
    repeat (8) frame();
    btn(0, 1, 1);
    repeat (9) frame();
    btn(1, 0, 0);
    btn(0, 0, 1);
    repeat (10) frame();
    btn(1, 0, 0);
    repeat (12) frame();
    do_reset();
    btn(1, 0, 0);
    btn(0, 1, 0);
    repeat (6) frame();
    for (int i = 1; i <= PRESS_EDGE; i++) begin
      bus.button_c = i <= HOLD;
      bus.collision = i == PRESS_EDGE;
      cyc();
    end
    bus.button_c = 0;
    bus.collision = 0;
    m_st = 3;
    m_cf = 0;
    chk("crash.enter", 32'(bus.regime_status), 32'd3);
    repeat (SETTLE + HOLD) cyc();
    btn(1, 1, 0);
    repeat (CRF + 2) frame();
    btn(1, 0, 0);
    repeat (8) frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
